// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE array control sequencer: command modes,
// sequencer states and the operand skew flush length.
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_MM   = 2'b00,
        MODE_FMUL = 2'b10,
        MODE_FADD = 2'b11
    } mode_e;

    // Encoding 2'b01 is reserved; a command carrying it is consumed and flagged.
    localparam logic [1:0] MODE_ILLEGAL = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_STREAM  = 3'd5,
        ST_FPWAIT  = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

    // Cycles needed for the last operand to cross the skewed array.
    function automatic int unsigned flush_len(input int unsigned rows, input int unsigned cols);
        return rows + cols - 32'd2;
    endfunction

    // True for the two FP stream command modes.
    function automatic logic is_fp_mode(input logic [1:0] m);
        return (m == MODE_FMUL) || (m == MODE_FADD);
    endfunction

endpackage

// File: rtl/pe_array_seq_chk.sv
// Protocol checker for pe_array_seq control outputs.
module pe_array_seq_chk (
    input logic clk,
    input logic rst_n,
    input logic psu_clr,
    input logic sys_buf_en,
    input logic feed_en,
    input logic done,
    input logic cmd_ready
);

    // Clearing and draining the accumulators must never coincide.
    a_clr_drain_excl: assert property (@(posedge clk) disable iff (!rst_n) !(psu_clr && sys_buf_en));

    // Operands must not be fed while accumulators are being drained.
    a_feed_drain_excl: assert property (@(posedge clk) disable iff (!rst_n) !(feed_en && sys_buf_en));

    // Completion is followed directly by readiness for the next command.
    a_done_ready: assert property (@(posedge clk) disable iff (!rst_n) done |=> cmd_ready);

endmodule

// File: rtl/seq_down_cnt.sv
// Loadable down counter with a zero flag; one instance times every phase.
module seq_down_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Load has priority; decrement saturates at zero so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/pe_array_seq.sv
// Sequencer for the shared control lines of a ROWS x COLS systolic PE array.
// All outputs are decoded from registered state (state, latched command,
// drain_valid and err flops) so nothing combinational leaks from inputs.
module pe_array_seq
    import pe_ctrl_pkg::*;
#(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int LEN_W  = 16,
    parameter int FP_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_ysel,
    output logic             feed_en,
    output logic [1:0]       mode_sel_out,
    output logic             y_sel_out,
    output logic             psu_clr_out,
    output logic             sys_buf_en_out,
    output logic             drain_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Counter reload values are phase length minus one.
    localparam logic [LEN_W-1:0] FLUSH_LD = LEN_W'(flush_len(ROWS, COLS) - 32'd1);
    localparam logic [LEN_W-1:0] DRAIN_LD = LEN_W'(ROWS - 1);
    localparam logic [LEN_W-1:0] FPW_LD   = LEN_W'(FP_LAT + ROWS - 2);
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    state_e           state_r;
    state_e           state_nxt_s;
    logic [1:0]       mode_r;
    logic [LEN_W-1:0] len_r;
    logic             ysel_r;
    logic             drain_valid_r;
    logic             err_r;
    logic             accept_s;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic [LEN_W-1:0] cnt_val_s;
    logic             cnt_zero_s;

    assign accept_s = cmd_valid && (state_r == ST_IDLE);

    seq_down_cnt #(.W(LEN_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .load_val (cnt_val_s),
        .zero     (cnt_zero_s)
    );

    // Next-state and phase counter control.
    always_comb begin
        state_nxt_s = state_r;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        cnt_val_s   = LEN_ZERO;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (cmd_mode == MODE_MM) begin
                    state_nxt_s = ST_CLEAR;
                end else if (is_fp_mode(cmd_mode)) begin
                    if (cmd_len == LEN_ZERO) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_STREAM;
                        cnt_load_s  = 1'b1;
                        cnt_val_s   = cmd_len - LEN_ONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cnt_load_s = 1'b1;
                if (len_r == LEN_ZERO) begin
                    state_nxt_s = ST_DRAIN;
                    cnt_val_s   = DRAIN_LD;
                end else begin
                    state_nxt_s = ST_COMPUTE;
                    cnt_val_s   = len_r - LEN_ONE;
                end
            end
            ST_COMPUTE: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_FLUSH;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = FLUSH_LD;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_DRAIN;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = DRAIN_LD;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_STREAM: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_FPWAIT;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = FPW_LD;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_FPWAIT: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command latch, captured on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= 2'b00;
            len_r  <= LEN_ZERO;
            ysel_r <= 1'b0;
        end else if (accept_s) begin
            mode_r <= cmd_mode;
            len_r  <= cmd_len;
            ysel_r <= cmd_ysel;
        end else begin
            mode_r <= mode_r;
            len_r  <= len_r;
            ysel_r <= ysel_r;
        end
    end

    // Drain valid trails sys_buf_en by one cycle (PE bottom output is registered);
    // err pulses for one cycle when an illegal command is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_valid_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            drain_valid_r <= (state_r == ST_DRAIN);
            err_r         <= accept_s && (cmd_mode == MODE_ILLEGAL);
        end
    end

    assign cmd_ready      = (state_r == ST_IDLE);
    assign busy           = (state_r != ST_IDLE);
    assign done           = (state_r == ST_DONE);
    assign feed_en        = (state_r == ST_COMPUTE) || (state_r == ST_STREAM);
    assign psu_clr_out    = (state_r == ST_CLEAR);
    assign sys_buf_en_out = (state_r == ST_DRAIN);
    assign mode_sel_out   = (state_r == ST_IDLE) ? 2'b00 : mode_r;
    assign y_sel_out      = ((state_r == ST_CLEAR) || (state_r == ST_COMPUTE) ||
                             (state_r == ST_FLUSH) || (state_r == ST_DRAIN)) ? ysel_r : 1'b0;
    assign drain_valid    = drain_valid_r;
    assign err            = err_r;

endmodule

// File: tb/tb_pe_array_seq.sv
// Randomized self-checking bench for pe_array_seq. The reference model
// computes, for each accepted command, the expected control outputs at cycle
// k after acceptance from the phase lengths alone.
module tb_pe_array_seq;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int LEN_W  = 6;
    localparam int FP_LAT = 3;
    localparam int FL     = ROWS + COLS - 2;
    localparam logic [10:0] IDLE_V = 11'b100_0000_0000;

    typedef struct {
        logic [1:0]       m;
        logic [LEN_W-1:0] l;
        logic             ys;
        int               gap;
    } cmd_t;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_ysel;
    logic             feed_en;
    logic [1:0]       mode_sel_out;
    logic             y_sel_out;
    logic             psu_clr_out;
    logic             sys_buf_en_out;
    logic             drain_valid;
    logic             busy;
    logic             done;
    logic             err;

    int   n_vec;
    int   n_err;
    int   cyc;
    cmd_t q[$];
    cmd_t cur;
    bit   act;
    int   k;

    pe_array_seq #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W), .FP_LAT(FP_LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_mode       (cmd_mode),
        .cmd_len        (cmd_len),
        .cmd_ysel       (cmd_ysel),
        .feed_en        (feed_en),
        .mode_sel_out   (mode_sel_out),
        .y_sel_out      (y_sel_out),
        .psu_clr_out    (psu_clr_out),
        .sys_buf_en_out (sys_buf_en_out),
        .drain_valid    (drain_valid),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    pe_array_seq_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .psu_clr    (psu_clr_out),
        .sys_buf_en (sys_buf_en_out),
        .feed_en    (feed_en),
        .done       (done),
        .cmd_ready  (cmd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (rdy,busy,done,err,feed,mode[2],ysel,clr,buf,dv)", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] get_outs();
        return {cmd_ready, busy, done, err, feed_en, mode_sel_out, y_sel_out,
                psu_clr_out, sys_buf_en_out, drain_valid};
    endfunction

    // Cycle (after acceptance) on which done pulses.
    function automatic int done_cyc(input cmd_t c);
        int n;
        n = int'(c.l);
        if (c.m == 2'b00) return ((n > 0) ? (n + 2 + FL) : 2) + ROWS;
        return (n > 0) ? (n + FP_LAT + ROWS) : 1;
    endfunction

    // Last cycle attributable to a command; the block is ready again there.
    function automatic int last_k(input cmd_t c);
        if (c.m == 2'b01) return 1;
        return done_cyc(c) + 1;
    endfunction

    function automatic logic [10:0] exp_vec(input cmd_t c, input int kk);
        logic rdy, bsy, dn, er, fe, ys, pc, sb, dv;
        logic [1:0] ms;
        int n, d0, dc;
        rdy = 1'b1; bsy = 1'b0; dn = 1'b0; er = 1'b0; fe = 1'b0;
        ys = 1'b0; pc = 1'b0; sb = 1'b0; dv = 1'b0; ms = 2'b00;
        n  = int'(c.l);
        dc = done_cyc(c);
        if (c.m == 2'b01) begin
            er = 1'b1;
        end else if (kk <= dc) begin
            rdy = 1'b0;
            bsy = 1'b1;
            dn  = (kk == dc);
            if (c.m == 2'b00) begin
                d0 = (n > 0) ? (n + 2 + FL) : 2;
                ys = (kk < dc) ? c.ys : 1'b0;
                pc = (kk == 1);
                fe = (kk >= 2) && (kk <= n + 1);
                sb = (kk >= d0) && (kk < d0 + ROWS);
                dv = (kk > d0) && (kk <= d0 + ROWS);
            end else begin
                ms = c.m;
                fe = (kk <= n);
            end
        end
        return {rdy, bsy, dn, er, fe, ms, ys, pc, sb, dv};
    endfunction

    // One clock: check outputs, drive the next input, advance the model.
    task automatic step();
        logic [10:0] e;
        bit   rdy_m;
        cmd_t h;
        @(negedge clk);
        cyc++;
        e = act ? exp_vec(cur, k) : IDLE_V;
        chk($sformatf("cyc%0d_k%0d_m%b_l%0d", cyc, act ? k : 0, cur.m, cur.l), get_outs(), e);
        rdy_m = !act || (k == last_k(cur));
        if (q.size() > 0 && q[0].gap > 0 && rdy_m) begin
            h = q[0];
            h.gap--;
            q[0] = h;
            cmd_valid = 1'b0;
        end else if (q.size() > 0) begin
            cmd_valid = 1'b1;
            cmd_mode  = q[0].m;
            cmd_len   = q[0].l;
            cmd_ysel  = q[0].ys;
        end else begin
            cmd_valid = 1'b0;
        end
        if (rdy_m && cmd_valid) begin
            cur = q.pop_front();
            act = 1'b1;
            k   = 1;
        end else if (act && k < last_k(cur)) begin
            k++;
        end else begin
            act = 1'b0;
        end
    endtask

    task automatic push(input logic [1:0] m, input int l, input logic ys, input int gap);
        cmd_t c;
        c.m = m; c.l = LEN_W'(l); c.ys = ys; c.gap = gap;
        q.push_back(c);
    endtask

    task automatic run_all();
        int guard;
        guard = 0;
        while ((q.size() > 0 || act) && guard < 20000) begin
            step();
            guard++;
        end
        if (guard >= 20000) chk("timeout", 11'd1, 11'd0);
        repeat (2) step();
    endtask

    initial begin
        int guard;
        n_vec = 0; n_err = 0; cyc = 0; act = 1'b0; k = 0;
        cur.m = 2'b00; cur.l = '0; cur.ys = 1'b0; cur.gap = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_len = '0; cmd_ysel = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", get_outs(), IDLE_V);
        cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_len = 6'd5;
        @(negedge clk);
        chk("reset_ignores_cmd", get_outs(), IDLE_V);
        cmd_valid = 1'b0;
        rst_n = 1'b1;

        // Directed cases from the plan, then boundaries.
        push(2'b00, 8, 1'b1, 0);
        push(2'b10, 5, 1'b1, 2);
        push(2'b01, 9, 1'b1, 2);
        push(2'b00, 0, 1'b1, 2);
        push(2'b11, 0, 1'b0, 2);
        push(2'b10, 3, 1'b0, 2);
        push(2'b00, 2, 1'b1, 0);
        push(2'b01, 4, 1'b0, 0);
        push(2'b11, 2, 1'b1, 0);
        push(2'b00, 63, 1'b1, 1);
        push(2'b11, 63, 1'b0, 1);
        push(2'b00, 1, 1'b0, 1);
        run_all();

        // Asynchronous reset in the middle of COMPUTE.
        push(2'b00, 12, 1'b1, 0);
        guard = 0;
        while (!(act && k == 5) && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) chk("rst_setup_timeout", 11'd1, 11'd0);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", get_outs(), IDLE_V);
        rst_n = 1'b1;
        act = 1'b0;
        q.delete();
        cmd_valid = 1'b0;
        push(2'b00, 3, 1'b1, 1);
        run_all();

        // Random commands with random gaps (0 keeps cmd_valid held).
        for (int i = 0; i < 40; i++) begin
            int l;
            l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
            push(2'($urandom_range(0, 3)), l, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
        run_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
